// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with an integer pixel-clock divider and a
// built-in test-pattern source; every output is registered and describes the same pixel.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CLK_DIV  = 2,
    parameter int   CNT_W    = 10,
    parameter int   COLOR_W  = 4,
    parameter int   CHK_LOG2 = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   en_i,
    input  logic [1:0]             mode_i,
    input  logic [3*COLOR_W-1:0]   colour_i,
    output logic                   pix_tick_o,
    output logic [CNT_W-1:0]       x_o,
    output logic [CNT_W-1:0]       y_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic                   line_o,
    output logic                   frame_o,
    output logic [COLOR_W-1:0]     red_o,
    output logic [COLOR_W-1:0]     green_o,
    output logic [COLOR_W-1:0]     blue_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

    localparam logic [1:0] MODE_SOLID  = 2'd0;
    localparam logic [1:0] MODE_BARS   = 2'd1;
    localparam logic [1:0] MODE_CHECK  = 2'd2;
    localparam logic [1:0] MODE_BORDER = 2'd3;

    localparam logic [COLOR_W-1:0] FULL = {COLOR_W{1'b1}};

    logic [DIV_W-1:0]   divCount_q, divCount_d;
    logic [CNT_W-1:0]   hCount_q, hCount_d;
    logic [CNT_W-1:0]   vCount_q, vCount_d;
    logic [1:0]         mode_q, mode_d;

    logic               pixTick_q, pixTick_d;
    logic [CNT_W-1:0]   xPos_q, xPos_d;
    logic [CNT_W-1:0]   yPos_q, yPos_d;
    logic               de_q, de_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic               line_q, line_d;
    logic               frame_q, frame_d;
    logic [COLOR_W-1:0] red_q, red_d;
    logic [COLOR_W-1:0] green_q, green_d;
    logic [COLOR_W-1:0] blue_q, blue_d;

    logic               tick;
    int                 hPos;
    int                 vPos;
    logic               frameStart;
    logic [1:0]         modeNow;
    logic               activeVid;
    logic               hsActive;
    logic               vsActive;
    logic               onBorder;
    logic [2:0]         barIdx;
    logic [COLOR_W-1:0] patRed, patGreen, patBlue;

    assign tick       = en_i && (divCount_q == DIV_LAST);
    assign hPos       = int'(hCount_q);
    assign vPos       = int'(vCount_q);
    assign frameStart = (hCount_q == '0) && (vCount_q == '0);

    // The first pixel of a frame already uses the freshly sampled mode so a frame never mixes patterns.
    assign modeNow    = frameStart ? mode_i : mode_q;

    assign activeVid  = (hPos < H_ACTIVE) && (vPos < V_ACTIVE);
    assign hsActive   = (hPos >= H_ACTIVE + H_FP) && (hPos < H_ACTIVE + H_FP + H_SYNC);
    assign vsActive   = (vPos >= V_ACTIVE + V_FP) && (vPos < V_ACTIVE + V_FP + V_SYNC);
    assign onBorder   = (hPos == 0) || (hPos == H_ACTIVE - 1) ||
                        (vPos == 0) || (vPos == V_ACTIVE - 1);

    always_comb begin
        divCount_d = divCount_q;
        if (!en_i || divCount_q == DIV_LAST) begin
            divCount_d = '0;
        end else begin
            divCount_d = divCount_q + DIV_W'(1);
        end
    end

    always_comb begin
        hCount_d = hCount_q;
        vCount_d = vCount_q;
        if (!en_i) begin
            hCount_d = '0;
            vCount_d = '0;
        end else if (tick) begin
            if (hCount_q == H_LAST) begin
                hCount_d = '0;
                vCount_d = (vCount_q == V_LAST) ? '0 : vCount_q + CNT_W'(1);
            end else begin
                hCount_d = hCount_q + CNT_W'(1);
            end
        end
    end

    assign mode_d = (tick && frameStart) ? mode_i : mode_q;

    // Bar index by threshold comparison avoids a divider by a non-power-of-two bar width.
    always_comb begin
        barIdx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (hPos >= k * BAR_W) begin
                barIdx = 3'(k);
            end
        end
    end

    always_comb begin
        patRed   = '0;
        patGreen = '0;
        patBlue  = '0;
        if (activeVid) begin
            case (modeNow)
                MODE_SOLID: begin
                    patRed   = colour_i[3*COLOR_W-1 -: COLOR_W];
                    patGreen = colour_i[2*COLOR_W-1 -: COLOR_W];
                    patBlue  = colour_i[COLOR_W-1:0];
                end
                MODE_BARS: begin
                    patRed   = {COLOR_W{barIdx[2]}};
                    patGreen = {COLOR_W{barIdx[1]}};
                    patBlue  = {COLOR_W{barIdx[0]}};
                end
                MODE_CHECK: begin
                    if (hCount_q[CHK_LOG2] ^ vCount_q[CHK_LOG2]) begin
                        patRed   = FULL;
                        patGreen = FULL;
                        patBlue  = FULL;
                    end
                end
                default: begin
                    if (onBorder) begin
                        patRed   = FULL;
                        patGreen = FULL;
                        patBlue  = FULL;
                    end else begin
                        patRed   = colour_i[3*COLOR_W-1 -: COLOR_W];
                        patGreen = colour_i[2*COLOR_W-1 -: COLOR_W];
                        patBlue  = colour_i[COLOR_W-1:0];
                    end
                end
            endcase
        end
    end

    // Outputs hold between ticks; the strobes fall back to zero on every non-tick cycle.
    always_comb begin
        pixTick_d = tick;
        line_d    = 1'b0;
        frame_d   = 1'b0;
        xPos_d    = xPos_q;
        yPos_d    = yPos_q;
        de_d      = de_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        red_d     = red_q;
        green_d   = green_q;
        blue_d    = blue_q;
        if (!en_i) begin
            xPos_d  = '0;
            yPos_d  = '0;
            de_d    = 1'b0;
            hs_d    = ~HS_POL;
            vs_d    = ~VS_POL;
            red_d   = '0;
            green_d = '0;
            blue_d  = '0;
        end else if (tick) begin
            xPos_d  = hCount_q;
            yPos_d  = vCount_q;
            de_d    = activeVid;
            hs_d    = hsActive ? HS_POL : ~HS_POL;
            vs_d    = vsActive ? VS_POL : ~VS_POL;
            line_d  = (hCount_q == '0);
            frame_d = frameStart;
            red_d   = patRed;
            green_d = patGreen;
            blue_d  = patBlue;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            divCount_q <= '0;
            hCount_q   <= '0;
            vCount_q   <= '0;
            mode_q     <= '0;
            pixTick_q  <= 1'b0;
            xPos_q     <= '0;
            yPos_q     <= '0;
            de_q       <= 1'b0;
            hs_q       <= ~HS_POL;
            vs_q       <= ~VS_POL;
            line_q     <= 1'b0;
            frame_q    <= 1'b0;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
        end else begin
            divCount_q <= divCount_d;
            hCount_q   <= hCount_d;
            vCount_q   <= vCount_d;
            mode_q     <= mode_d;
            pixTick_q  <= pixTick_d;
            xPos_q     <= xPos_d;
            yPos_q     <= yPos_d;
            de_q       <= de_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            line_q     <= line_d;
            frame_q    <= frame_d;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
        end
    end

    assign pix_tick_o = pixTick_q;
    assign x_o        = xPos_q;
    assign y_o        = yPos_q;
    assign de_o       = de_q;
    assign hs_o       = hs_q;
    assign vs_o       = vs_q;
    assign line_o     = line_q;
    assign frame_o    = frame_q;
    assign red_o      = red_q;
    assign green_o    = green_q;
    assign blue_o     = blue_q;

endmodule
